wb_ram_slave: RTL and testbench
===============================

WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 12; number of word-address bits, giving 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000; byte address of word 0, aligned to the window size.
REQ-003 Parameter WAIT_STATES, default 1; extra cycles inserted before each ack/err, range 0..15.
REQ-004 The block SHALL use one clock, clk_i; reset is synchronous and active-low on rst_i.
REQ-005 clk_i  input  1  rising-edge clock.
REQ-006 rst_i  input  1  synchronous reset, active-low.
REQ-007 wb_adr_i  input  32  byte address from the Wishbone master.
REQ-008 wb_dat_i  input  32  write data.
REQ-009 wb_sel_i  input  4  byte lane enables; sel[3] is dat[31:24], the lowest byte address (big-endian).
REQ-010 wb_we_i  input  1  1 = write, 0 = read.
REQ-011 wb_cyc_i, wb_stb_i  input  1 each  bus cycle and strobe.
REQ-012 wb_dat_o  output  32  read data.
REQ-013 wb_ack_o  output  1  normal termination.
REQ-014 wb_err_o  output  1  error termination.

Function
REQ-015 The block SHALL implement a Wishbone classic single-transfer responder using states IDLE, WAIT and RESP.
- REQ-016 IDLE: when cyc&stb=1, capture adr, dat, sel and we; load the wait counter with WAIT_STATES; go to WAIT, or go to RESP if WAIT_STATES=0.
- REQ-017 WAIT: decrement the counter each cycle; at 0, go to RESP.
- REQ-018 RESP: assert exactly one of ack/err for exactly one cycle, then return to IDLE.
REQ-019 Latency SHALL be WAIT_STATES+1 cycles from the first clk_i edge sampling cyc&stb=1 to ack/err=1.
REQ-020 After RESP, the block SHALL sample the request only in IDLE, so back-to-back requests cost WAIT_STATES+2 cycles each.
REQ-021 A request SHALL be an error when the captured adr lies outside [BASE_ADDR, BASE_ADDR+4*2^ADDR_WIDTH) or adr[1:0]!=0; err=1, ack=0, and memory is unchanged.
REQ-022 Writes SHALL commit only the lanes with sel=1, on the RESP edge; sel=4'b0000 SHALL ack without any write.
REQ-023 Read data SHALL be valid on wb_dat_o in the RESP cycle; wb_dat_o=0 in every other cycle. Unselected lanes return stored data.
REQ-024 Abort: if cyc or stb drops while in WAIT, the block SHALL go to IDLE on the next edge with no ack, no err and no write.
REQ-025 A read from a word in the same or a later request after a write to that word SHALL return the new data (no stale read).
REQ-026 wb_ack_o and wb_err_o SHALL never be 1 together and SHALL be registered outputs (no combinational path from inputs).

Reset
REQ-027 When rst_i=0 at an edge, the block SHALL set: state=IDLE, counter=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0.
REQ-028 Reset mid-transfer SHALL abandon the transfer with no write and no ack; memory contents are not cleared.
REQ-029 The first request SHALL be accepted on the first edge after rst_i returns to 1.

Structure
REQ-030 Package moxie_wb_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the byte-lane index constants, and the address-decode helper.
REQ-031 The memory SHALL be a sub-module wb_ram_array: a single-port synchronous RAM, 2^ADDR_WIDTH x 32, with 4 byte write enables and 1-cycle read; its read is issued in the cycle before RESP.
REQ-032 The RTL SHALL target 120-400 lines, excluding the package.

Verification
REQ-033 The bench SHALL cover the following directed scenarios (defaults unless stated):
- REQ-034 Write adr=0x10, dat=0xDEADBEEF, sel=F, then read 0x10 -> ack 2 cycles after each stb; read data 0xDEADBEEF; err never set.
- REQ-035 Write 0x10 sel=4'b0100 dat=0x00AA0000 over 0xDEADBEEF, then read -> 0xDEAABEEF.
- REQ-036 Read adr=0x4000 (out of range) and adr=0x12 (misaligned) -> err for one cycle at latency 2; ack=0; a subsequent read of 0x10 is unchanged.
- REQ-037 WAIT_STATES=3, write 0x20 with stb dropped after 2 cycles -> no ack/err; a later read of 0x20 returns its prior value.
- REQ-038 WAIT_STATES=0, four back-to-back reads with stb held high -> ack pulses 2 cycles apart, dat_o=0 between pulses.
- REQ-039 Assert rst_i=0 in WAIT during a write of 0x55555555 to 0x30 -> ack stays 0; after reset a read of 0x30 returns the old data.

Source files
------------

// File: rtl/moxie_wb_pkg.sv
// Shared types and helpers for the Wishbone RAM responder: FSM states,
// byte-lane indexing and the address window / alignment decode.
package moxie_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // Big-endian lanes: lane 3 carries dat[31:24], the lowest byte address.
  localparam int unsigned NUM_LANES  = 4;
  localparam int unsigned LANE_BITS  = 8;
  localparam int unsigned LANE_BYTE0 = 3;
  localparam int unsigned LANE_BYTE3 = 0;

  // True when adr is word-aligned and inside [base, base + 4*2^aw).
  function automatic logic addr_hit(input logic [31:0] adr,
                                    input logic [31:0] base,
                                    input int unsigned aw);
    logic [32:0] offset;
    logic [32:0] span;
    offset = {1'b0, adr} - {1'b0, base};
    span   = 33'd4 << aw;
    return (adr >= base) && (offset < span) && (adr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/wb_ram_array.sv
// Single-port synchronous RAM, 2^ADDR_WIDTH x 32, per-lane write enables and
// a registered read port (data appears the cycle after i_rd_en).
module wb_ram_array
  import moxie_wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  i_rd_en,
  input  logic [NUM_LANES-1:0]  i_wr_be,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**ADDR_WIDTH];
  logic [31:0] r_rdata;

  // Contents are intentionally never reset.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (i_wr_be[l]) begin
        r_mem[i_addr][l*LANE_BITS +: LANE_BITS] <= i_wdata[l*LANE_BITS +: LANE_BITS];
      end
    end
    if (i_rd_en) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic single-transfer RAM responder with programmable wait
// states; out-of-window or misaligned accesses terminate with err.
module wb_ram_slave
  import moxie_wb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  // Handshake: a request is cyc&stb sampled in IDLE; it is held by the master
  // until ack or err, each a single-cycle pulse driven only from registers.
  wb_state_e             r_state;
  wb_state_e             w_next_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_word;
  logic [31:0]           r_dat;
  logic [3:0]            r_sel;
  logic                  r_we;
  logic                  r_err;

  logic                  w_req;
  logic                  w_take;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic                  w_rd_en;
  logic [3:0]            w_wr_be;
  logic [31:0]           w_rdata;

  assign w_req  = wb_cyc_i & wb_stb_i;
  assign w_take = (r_state == IDLE) & w_req;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_take) begin
        r_cnt <= WS;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Error status is decided at capture so ack/err need no input-side logic.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_word <= '0;
      r_dat  <= '0;
      r_sel  <= '0;
      r_we   <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_take) begin
      r_word <= wb_adr_i[ADDR_WIDTH+1:2];
      r_dat  <= wb_dat_i;
      r_sel  <= wb_sel_i;
      r_we   <= wb_we_i;
      r_err  <= ~addr_hit(wb_adr_i, BASE_ADDR, ADDR_WIDTH);
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next_state = (WS == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_next_state = IDLE;
        end else if (r_cnt <= 4'd1) begin
          w_next_state = RESP;
        end
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    wb_ack_o = 1'b0;
    wb_err_o = 1'b0;
    wb_dat_o = '0;
    if (r_state == RESP) begin
      wb_ack_o = ~r_err;
      wb_err_o = r_err;
      if (!r_err && !r_we) begin
        wb_dat_o = w_rdata;
      end
    end
  end

  // The read is launched on the edge entering RESP; with zero wait states
  // that edge is the accept edge, so the address comes straight off the bus.
  assign w_ram_addr  = (r_state == IDLE) ? wb_adr_i[ADDR_WIDTH+1:2] : r_word;
  assign w_rd_en     = (w_next_state == RESP);
  assign w_wr_be     = (r_state == RESP && r_we && !r_err && rst_i) ? r_sel : 4'b0000;
  assign dbg_state_o = r_state;

  wb_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .i_rd_en (w_rd_en),
    .i_wr_be (w_wr_be),
    .i_addr  (w_ram_addr),
    .i_wdata (r_dat),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed bench for wb_ram_slave at three wait-state settings; responses are
// predicted into a queue and checked by a monitor on the falling edge.
module tb_wb_ram_slave;
  import moxie_wb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic        rst_n [3];
  logic        cyc   [3];
  logic        stb   [3];
  logic        we    [3];
  logic [31:0] adr   [3];
  logic [31:0] dat_i [3];
  logic [3:0]  sel   [3];
  logic [31:0] dat_o [3];
  logic        ack   [3];
  logic        err   [3];
  logic [1:0]  dbg   [3];

  int checks = 0;
  int passes = 0;

  // {dut[51:50], cycle[49:34], check_data[33], err[32], data[31:0]}
  logic [51:0] exp_q[$];

  wb_ram_slave #(.WAIT_STATES(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n[0]), .wb_adr_i(adr[0]), .wb_dat_i(dat_i[0]),
    .wb_sel_i(sel[0]), .wb_we_i(we[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
    .wb_dat_o(dat_o[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .dbg_state_o(dbg[0]));

  wb_ram_slave #(.WAIT_STATES(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n[1]), .wb_adr_i(adr[1]), .wb_dat_i(dat_i[1]),
    .wb_sel_i(sel[1]), .wb_we_i(we[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
    .wb_dat_o(dat_o[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .dbg_state_o(dbg[1]));

  wb_ram_slave #(.WAIT_STATES(0)) u_dut2 (
    .clk_i(clk), .rst_i(rst_n[2]), .wb_adr_i(adr[2]), .wb_dat_i(dat_i[2]),
    .wb_sel_i(sel[2]), .wb_we_i(we[2]), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]),
    .wb_dat_o(dat_o[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]), .dbg_state_o(dbg[2]));

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %08h, required %08h (t=%0t)", name, act, expv, $time);
  endtask

  // Monitor: every response must match the head of the queue; otherwise dat_o is 0.
  always @(negedge clk) begin
    if (cycle >= 2) begin
      for (int d = 0; d < 3; d++) begin
        if (ack[d] === 1'b1 || err[d] === 1'b1) begin
          check($sformatf("ack_err_excl_dut%0d", d), {31'b0, ack[d] & err[d]}, 32'd0);
          if (exp_q.size() == 0 || exp_q[0][51:50] != 2'(d)) begin
            checks++;
            $display("FAIL unexpected_resp_dut%0d: got ack=%0b err=%0b at cycle %0d, required no response",
                     d, ack[d], err[d], cycle);
          end else begin
            logic [51:0] e;
            e = exp_q.pop_front();
            check($sformatf("resp_cycle_dut%0d", d), 32'(cycle), {16'b0, e[49:34]});
            check($sformatf("resp_err_dut%0d", d), {31'b0, err[d]}, {31'b0, e[32]});
            if (e[33]) check($sformatf("read_data_dut%0d", d), dat_o[d], e[31:0]);
          end
        end else begin
          check($sformatf("dat_idle_zero_dut%0d", d), dat_o[d], 32'd0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] dt,
                      input logic [3:0] s, input logic e_err, input logic [31:0] e_dat);
    bit seen;
    seen     = 1'b0;
    cyc[d]   = 1'b1;
    stb[d]   = 1'b1;
    we[d]    = w;
    adr[d]   = a;
    dat_i[d] = dt;
    sel[d]   = s;
    exp_q.push_back({2'(d), 16'(cycle + 1 + ws_of(d)), ~w & ~e_err, e_err, e_dat});
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack[d] === 1'b1 || err[d] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      $display("FAIL resp_timeout_dut%0d: got no ack/err within 40 cycles, required one", d);
    end
    @(posedge clk);
    #1;
    cyc[d] = 1'b0;
    stb[d] = 1'b0;
  endtask

  task automatic b2b_reads(input int d, input logic [31:0] a, input logic [31:0] e_dat, input int n);
    int per;
    per    = ws_of(d) + 2;
    cyc[d] = 1'b1;
    stb[d] = 1'b1;
    we[d]  = 1'b0;
    adr[d] = a;
    sel[d] = 4'hF;
    for (int k = 0; k < n; k++)
      exp_q.push_back({2'(d), 16'(cycle + 1 + ws_of(d) + k * per), 1'b1, 1'b0, e_dat});
    repeat (n * per) @(posedge clk);
    #1;
    cyc[d] = 1'b0;
    stb[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required $finish before 200us");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = '0; dat_i[d] = '0; sel[d] = '0;
    end
    idle(3);
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check("rst_state", {30'b0, dbg[d]}, 32'(IDLE));
      check("rst_ack", {31'b0, ack[d]}, 32'd0);
      check("rst_err", {31'b0, err[d]}, 32'd0);
      check("rst_dat", dat_o[d], 32'd0);
    end

    // One wait state: full write, partial write, empty sel, errors, boundary.
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);
    xfer(0, 1'b1, 32'h10, 32'h00AA0000, 4'b0100, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEAABEEF);
    xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'b0001, 1'b0, 32'hDEAABEEF);
    xfer(0, 1'b1, 32'h0, 32'h01020304, 4'hF, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h4000, 32'h0, 4'hF, 1'b1, 32'h0);
    xfer(0, 1'b0, 32'h12, 32'h0, 4'hF, 1'b1, 32'h0);
    xfer(0, 1'b1, 32'h4000, 32'hBAD0BAD0, 4'hF, 1'b1, 32'h0);
    xfer(0, 1'b1, 32'h12, 32'hBAD1BAD1, 4'hF, 1'b1, 32'h0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEAABEEF);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 32'h01020304);
    xfer(0, 1'b1, 32'h3FFC, 32'hA5A55A5A, 4'hF, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h3FFC, 32'h0, 4'hF, 1'b0, 32'hA5A55A5A);

    // Reset while waiting on a write: no ack, memory keeps the old word.
    xfer(0, 1'b1, 32'h30, 32'h12345678, 4'hF, 1'b0, 32'h0);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
    adr[0] = 32'h30; dat_i[0] = 32'h55555555; sel[0] = 4'hF;
    idle(1);
    check("mid_wait_state", {30'b0, dbg[0]}, 32'(WAIT));
    rst_n[0] = 1'b0;
    idle(1);
    rst_n[0] = 1'b1; cyc[0] = 1'b0; stb[0] = 1'b0;
    check("mid_rst_state", {30'b0, dbg[0]}, 32'(IDLE));
    idle(2);
    xfer(0, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 32'h12345678);

    // Three wait states: abort after two cycles of strobe.
    xfer(1, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0);
    xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h11223344);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = 32'h20; dat_i[1] = 32'hCAFEF00D; sel[1] = 4'hF;
    idle(2);
    stb[1] = 1'b0;
    idle(1);
    cyc[1] = 1'b0;
    check("abort_state", {30'b0, dbg[1]}, 32'(IDLE));
    idle(4);
    xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h11223344);
    xfer(1, 1'b0, 32'h12, 32'h0, 4'hF, 1'b1, 32'h0);

    // Zero wait states: back-to-back reads with strobe held.
    xfer(2, 1'b1, 32'h10, 32'hCAFEBABE, 4'hF, 1'b0, 32'h0);
    b2b_reads(2, 32'h10, 32'hCAFEBABE, 4);
    xfer(2, 1'b0, 32'h4000, 32'h0, 4'hF, 1'b1, 32'h0);

    idle(5);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
